// File: rtl/pipe_pkg.sv
// pipe_pkg: shared state encoding and widths for the pipeline stage register
package pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        MAIN  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam int FLUSH_CNT_W = 8;

endpackage

// File: rtl/sat_counter.sv
// sat_counter: up-counter that sticks at its all-ones value
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_inc && !(&r_cnt))
            r_cnt <= r_cnt + 1'b1;
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline register with optional skid entry, freeze, flush and flush counter
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int PC_W = 16,
    parameter int IR_W = 32,
    parameter int SKID = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   freeze,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [PC_W-1:0]        i_PC,
    input  logic [IR_W-1:0]        i_IR,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [PC_W-1:0]        o_PC,
    output logic [IR_W-1:0]        o_IR,
    output logic [FLUSH_CNT_W-1:0] flush_cnt
);

    state_t          r_state, w_next;
    logic [PC_W-1:0] r_pc, r_skid_pc;
    logic [IR_W-1:0] r_ir, r_skid_ir;
    logic            w_in_fire, w_out_fire, w_flush_eff, w_load_main, w_load_skid;

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= EMPTY;
        else
            r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        if (freeze)
            w_next = r_state;
        else if (flush)
            w_next = EMPTY;
        else
            case (r_state)
                EMPTY:   w_next = w_in_fire ? MAIN : EMPTY;
                MAIN:    w_next = (w_in_fire && !w_out_fire && SKID != 0) ? FULL :
                                  (!w_in_fire && w_out_fire) ? EMPTY : MAIN;
                FULL:    w_next = w_out_fire ? MAIN : FULL;
                default: w_next = EMPTY;
            endcase
    end

    // Without the skid entry, ready must look through to out_ready to keep full throughput.
    always_comb begin
        out_valid   = !freeze && r_state != EMPTY;
        in_ready    = (SKID != 0) ? (!freeze && r_state != FULL)
                                  : (!freeze && (!out_valid || out_ready));
        w_load_main = !freeze && !flush &&
                      ((r_state == EMPTY) ? w_in_fire :
                       (r_state == MAIN)  ? (w_in_fire && w_out_fire) :
                       (r_state == FULL)  ? w_out_fire : 1'b0);
        w_load_skid = !freeze && !flush && SKID != 0 &&
                      r_state == MAIN && w_in_fire && !w_out_fire;
        w_flush_eff = flush && !freeze && r_state != EMPTY;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_skid_pc <= '0;
            r_skid_ir <= '0;
        end else if (!freeze && flush) begin
            r_pc      <= '0;
            r_ir      <= '0;
            r_skid_pc <= '0;
            r_skid_ir <= '0;
        end else begin
            if (w_load_main) begin
                r_pc <= (r_state == FULL) ? r_skid_pc : i_PC;
                r_ir <= (r_state == FULL) ? r_skid_ir : i_IR;
            end
            if (w_load_skid) begin
                r_skid_pc <= i_PC;
                r_skid_ir <= i_IR;
            end
        end
    end

    assign o_PC = r_pc;
    assign o_IR = r_ir;

    sat_counter #(.W(FLUSH_CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .i_inc (w_flush_eff),
        .o_cnt (flush_cnt)
    );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg
module tb_pipe_stage_reg;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        freeze = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] i_PC = '0;
    logic [31:0] i_IR = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] o_PC;
    logic [31:0] o_IR;
    logic [7:0]  flush_cnt;
    int          n_tests = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pipe_stage_reg dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .freeze    (freeze),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .i_PC      (i_PC),
        .i_IR      (i_IR),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .o_PC      (o_PC),
        .o_IR      (o_IR),
        .flush_cnt (flush_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1;
        chk("rst_valid", out_valid, 0);
        chk("rst_pc", o_PC, 0);
        chk("rst_cnt", flush_cnt, 0);
        chk("rst_ready", in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            i_PC = 16'(i);
            i_IR = 32'(i + 100);
            step();
            chk("b2b_pc", o_PC, i);
            chk("b2b_ir", o_IR, i + 100);
            chk("b2b_valid", out_valid, 1);
            chk("b2b_ready", in_ready, 1);
        end
        in_valid = 1'b0;
        step();
        chk("b2b_drain", out_valid, 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        i_PC      = 16'h0010;
        step();
        chk("bp_first", o_PC, 16'h0010);
        chk("bp_ready_main", in_ready, 1);
        i_PC = 16'h0014;
        step();
        chk("bp_full_ready", in_ready, 0);
        chk("bp_full_pc", o_PC, 16'h0010);
        chk("bp_full_valid", out_valid, 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        chk("bp_second", o_PC, 16'h0014);
        chk("bp_second_valid", out_valid, 1);
        step();
        chk("bp_empty", out_valid, 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        i_PC      = 16'h0020;
        i_IR      = 32'hDEADBEEF;
        step();
        i_PC = 16'h0024;
        i_IR = 32'h11111111;
        step();
        chk("fl_full_ir", o_IR, 32'hDEADBEEF);
        flush = 1'b1;
        i_PC  = 16'h0099;
        i_IR  = 32'h00000099;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_ir", o_IR, 0);
        chk("fl_pc", o_PC, 0);
        chk("fl_cnt", flush_cnt, 1);
        step();
        chk("fl_no_beat", out_valid, 0);
        in_valid = 1'b1;
        i_PC     = 16'h0030;
        step();
        flush = 1'b1;
        i_PC  = 16'h0034;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("fl_main_cnt", flush_cnt, 2);
        step();
        chk("fl_main_drop", out_valid, 0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("fl_empty_cnt", flush_cnt, 2);

        in_valid = 1'b1;
        i_PC     = 16'h0040;
        step();
        i_PC      = 16'h0050;
        out_ready = 1'b1;
        freeze    = 1'b1;
        flush     = 1'b1;
        #1;
        chk("fz_ready", in_ready, 0);
        chk("fz_valid_now", out_valid, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("fz_pc", o_PC, 16'h0040);
            chk("fz_valid", out_valid, 0);
            chk("fz_cnt", flush_cnt, 2);
        end
        freeze    = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("fz_release_valid", out_valid, 1);
        chk("fz_release_pc", o_PC, 16'h0040);
        out_ready = 1'b1;
        step();
        chk("fz_drain", out_valid, 0);

        out_ready = 1'b0;
        in_valid  = 1'b1;
        i_PC      = 16'h0060;
        step();
        i_PC = 16'h0064;
        step();
        chk("rs_full", in_ready, 0);
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rs_valid", out_valid, 0);
        chk("rs_pc", o_PC, 0);
        chk("rs_ir", o_IR, 0);
        chk("rs_cnt", flush_cnt, 0);
        chk("rs_ready", in_ready, 1);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        i_PC      = 16'h0070;
        step();
        chk("rs_lat_pc", o_PC, 16'h0070);
        chk("rs_lat_valid", out_valid, 1);
        in_valid = 1'b0;
        step();
        chk("rs_lat_drain", out_valid, 0);

        out_ready = 1'b0;
        for (int i = 1; i <= 300; i++) begin
            flush    = 1'b0;
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            flush    = 1'b1;
            step();
            chk("sat_cnt", flush_cnt, (i > 255) ? 255 : i);
        end
        flush = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter PC_W, default 16, meaning program-counter field width.
REQ-002 SHALL have parameter IR_W, default 32, meaning instruction field width.
REQ-003 SHALL have parameter SKID, default 1, meaning 1 enables the 2-entry skid buffer and 0 gives a single entry.
REQ-004 SHALL have port clk  in  1  meaning the single clock; all state updates on rising edge.
REQ-005 SHALL have port rst_n  in  1  meaning asynchronous, active-low reset.
REQ-006 SHALL have port freeze  in  1  meaning hold all state.
REQ-007 SHALL have port flush  in  1  meaning discard all held and incoming entries.
REQ-008 SHALL have port in_valid  in  1  meaning upstream beat present.
REQ-009 SHALL have port in_ready  out  1  meaning stage accepts a beat.
REQ-010 SHALL have port i_PC  in  PC_W  meaning upstream PC.
REQ-011 SHALL have port i_IR  in  IR_W  meaning upstream instruction.
REQ-012 SHALL have port out_valid  out  1  meaning downstream beat present.
REQ-013 SHALL have port out_ready  in  1  meaning downstream accepts.
REQ-014 SHALL have port o_PC  out  PC_W  meaning registered PC.
REQ-015 SHALL have port o_IR  out  IR_W  meaning registered instruction.
REQ-016 SHALL have port flush_cnt  out  8  meaning saturating count of effective flushes.

Function
REQ-017 SHALL define in_fire = in_valid & in_ready and out_fire = out_valid & out_ready.
REQ-018 SHALL implement states EMPTY (no entry), MAIN (output entry valid, skid empty) and FULL (output and skid entries valid); FULL is unreachable when SKID=0.
REQ-019 SHALL drive in_ready from registered state only: 1 in EMPTY/MAIN, 0 in FULL, and 0 whenever freeze=1.
REQ-020 SHALL drive out_valid=1 in MAIN/FULL and 0 in EMPTY or whenever freeze=1, with o_PC/o_IR always showing the output entry.
REQ-021 SHALL, when SKID=0, drive in_ready = ~out_valid | out_ready (combinational path permitted only in this mode).
REQ-022 SHALL give one-cycle latency: a beat accepted at edge N appears on o_PC/o_IR after edge N when the stage was EMPTY, or when it was MAIN with out_fire.
REQ-023 SHALL perform the following transitions when freeze=0 and flush=0: EMPTY+in_fire -> MAIN; MAIN+in_fire+out_fire -> MAIN (new data); MAIN+in_fire+~out_fire -> FULL (beat to skid); MAIN+out_fire+~in_fire -> EMPTY; FULL+out_fire -> MAIN (skid moves to output); no fire -> same state.
REQ-024 SHALL preserve beat order and never drop or duplicate a beat except on flush.
REQ-025 SHALL, on freeze=1, keep state, entries and flush_cnt unchanged regardless of flush, in_valid and out_ready (freeze outranks flush).
REQ-026 SHALL, on flush=1 with freeze=0, go to EMPTY at the next edge, zero o_PC/o_IR and the skid entry, and discard any same-cycle incoming beat.
REQ-027 SHALL count a flush as effective when flush=1, freeze=0 and the state is not EMPTY.
REQ-028 SHALL increment flush_cnt by 1 per effective flush and saturate at 255.
REQ-029 SHALL let downstream consume data presented with out_valid=1 in a flush cycle; the entry is still cleared.

Reset
REQ-030 SHALL, on rst_n=0, immediately and asynchronously force state EMPTY, o_PC=0, o_IR=0, skid entry 0 and flush_cnt=0.
REQ-031 SHALL abandon any in-flight beat on reset mid-operation and resume normally at the first edge after rst_n rises.

Structure
REQ-032 SHALL place the state encoding (EMPTY=2'd0, MAIN=2'd1, FULL=2'd2) and the flush_cnt width constant in shared package pipe_pkg.
REQ-033 SHALL place the saturating flush counter in sub-module sat_counter, parameterised by width.

Verification
REQ-034 SHALL verify back-to-back flow: in_valid=1 with PC 0x0000..0x0009 and out_ready=1 -> each PC appears on o_PC one cycle later, in order, with in_ready constantly 1.
REQ-035 SHALL verify backpressure: out_ready=0 while two beats PC 0x0010 and 0x0014 arrive -> state FULL and in_ready=0; then out_ready=1 -> 0x0010 then 0x0014 delivered, with no loss.
REQ-036 SHALL verify flush: flush=1 in FULL with IR 0xDEADBEEF held -> next cycle out_valid=0, o_IR=0, flush_cnt=1, and a same-cycle input beat is absent.
REQ-037 SHALL verify freeze over flush: freeze=1 and flush=1 together for 3 cycles in MAIN with PC 0x0040 -> o_PC stays 0x0040, out_valid=0 and flush_cnt unchanged; release -> out_valid=1.
REQ-038 SHALL verify reset: rst_n low mid-cycle in FULL -> outputs immediately 0 with flush_cnt=0, and after release the first beat has one-cycle latency.
REQ-039 SHALL verify saturation: 300 effective flushes -> flush_cnt=255.
